// File: rtl/fp_accumulator_if.sv
// fp_accumulator_if: start/len command, element stream and result port of the accumulator
interface fp_accumulator_if #(parameter int COUNT_W = 8);
  logic               start;
  logic [COUNT_W-1:0] len;
  logic               in_valid;
  logic [31:0]        in_data;
  logic               in_ready;
  logic               out_valid;
  logic [31:0]        out_data;
  logic               out_ready;
  logic               busy;
  modport master (output start, len, in_valid, in_data, out_ready, input in_ready, out_valid, out_data, busy);
  modport slave (input start, len, in_valid, in_data, out_ready, output in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/fp_accumulator.sv
// fp_accumulator: reduces a length-prefixed stream of IEEE-754 singles through one combinational adder
module adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out
);
  logic        w_swap;
  logic [31:0] w_x, w_y;
  logic [7:0]  w_d, w_e;
  logic [24:0] w_mx, w_my, w_sum;
  logic [4:0]  w_lz;
  logic [23:0] w_norm;
  // larger magnitude goes to x; hidden 1 is always inserted, result truncates
  always_comb begin
    w_swap = b[30:0] > a[30:0];
    w_x = w_swap ? b : a;
    w_y = w_swap ? a : b;
    w_d = w_x[30:23] - w_y[30:23];
    w_mx = {2'b01, w_x[22:0]};
    w_my = {2'b01, w_y[22:0]} >> w_d;
    w_sum = (w_x[31] == w_y[31]) ? w_mx + w_my : w_mx - w_my;
    w_lz = 5'd0;
    for (int i = 0; i < 24; i++) if (w_sum[i]) w_lz = 5'(23 - i);
    w_norm = w_sum[24] ? w_sum[24:1] : w_sum[23:0] << w_lz;
    w_e = w_sum[24] ? w_x[30:23] + 8'd1 : w_x[30:23] - {3'b000, w_lz};
    out = (w_sum == 25'd0) ? 32'h0000_0000 : {w_x[31], w_e, w_norm[22:0]};
  end
endmodule

module fp_accumulator #(parameter int COUNT_W = 8) (
  input logic            clk,
  input logic            rst_n,
  fp_accumulator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCEPT, ADD, DONE} state_t;
  state_t             r_state;
  logic [31:0]        r_acc, r_op;
  logic [COUNT_W-1:0] r_rem;
  logic               r_first, r_in_ready, r_out_valid, r_busy;
  logic [31:0]        w_sum;
  adder u_add (.a(r_acc), .b(r_op), .out(w_sum));
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_acc;
  assign bus.busy      = r_busy;
  // the first element is loaded straight into acc since the adder cannot add to a true zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_op        <= '0;
      r_rem       <= '0;
      r_first     <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_busy <= 1'b1;
          if (bus.len == '0) begin
            r_acc       <= '0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_rem      <= bus.len;
            r_first    <= 1'b1;
            r_in_ready <= 1'b1;
            r_state    <= ACCEPT;
          end
        end
        ACCEPT: if (bus.in_valid) begin
          r_rem <= r_rem - COUNT_W'(1);
          if (r_first) begin
            r_acc   <= bus.in_data;
            r_first <= 1'b0;
            if (r_rem == COUNT_W'(1)) begin
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end
          end else begin
            r_op       <= bus.in_data;
            r_in_ready <= 1'b0;
            r_state    <= ADD;
          end
        end
        ADD: begin
          r_acc <= w_sum;
          if (r_rem == '0) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_in_ready <= 1'b1;
            r_state    <= ACCEPT;
          end
        end
        DONE: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_accumulator.sv
// tb_fp_accumulator: directed and randomized reductions checked against exact quarter-unit sums
module tb_fp_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;
  always #5 clk = ~clk;
  fp_accumulator_if #(.COUNT_W(8)) bus ();
  fp_accumulator #(.COUNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // exact single-precision encoding of q/4
  function automatic logic [31:0] q2f(input int q);
    int m, p;
    logic [31:0] r;
    if (q == 0) return 32'h0;
    m = q < 0 ? -q : q;
    p = 0;
    for (int i = 0; i < 31; i++) if (m[i]) p = i;
    r[31] = q < 0;
    r[30:23] = 8'(p + 125);
    r[22:0] = 23'(m << (23 - p));
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input int n);
    bus.start = 1'b1;
    bus.len = 8'(n);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input int gap);
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      bus.in_data = $urandom;
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_data = d;
    for (int t = 0; t <= 50; t++) begin
      if (t == 50) begin
        total++; bad++;
        $display("FAIL send_timeout in_ready=0 required=1");
      end else if (bus.in_ready) begin
        tick();
        break;
      end else tick();
    end
    bus.in_valid = 1'b0;
    bus.in_data = $urandom;
  endtask

  task automatic collect(output logic [31:0] d, output int lat, input int hold);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (!bus.out_valid) begin
      total++; bad++;
      $display("FAIL collect_timeout out_valid=0 required=1");
    end
    repeat (hold) tick();
    d = bus.out_data;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    int lat;
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data got=%h want=00000000", bus.out_data); end
    tick();
    rst_n = 1'b1;
    tick();
    start_op(3);
    send(q2f(4), 0);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b want=1", bus.in_ready); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL abort_in_ready got=%b want=0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL abort_out_valid got=%b want=0", bus.out_valid); end
    tick();
    rst_n = 1'b1;
    tick();
    start_op(1);
    send(32'h3F80_0000, 0);
    collect(d, lat, 0);
    total++; if (d !== 32'h3F80_0000) begin bad++; $display("FAIL after_rst_sum got=%h want=3f800000", d); end
    total++; if (lat !== 0) begin bad++; $display("FAIL after_rst_latency got=%0d want=0", lat); end
  endtask

  task automatic test_sign_mix;
    logic [31:0] d;
    int lat;
    start_op(2);
    send(32'hBF00_0000, 0);
    send(32'h3F40_0000, 0);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL sign_early_valid got=%b want=0", bus.out_valid); end
    collect(d, lat, 0);
    total++; if (lat !== 1) begin bad++; $display("FAIL sign_latency got=%0d want=1", lat); end
    total++; if (d !== 32'h3E80_0000) begin bad++; $display("FAIL sign_sum got=%h want=3e800000", d); end
  endtask

  task automatic test_three_term;
    logic [31:0] v [3];
    logic [4:0]  pat;
    logic [31:0] d;
    int idx, lat;
    logic r;
    v[0] = 32'h3F80_0000; v[1] = 32'h4000_0000; v[2] = 32'h4040_0000;
    idx = 0;
    start_op(3);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = idx < 3;
      bus.in_data = v[idx < 3 ? idx : 0];
      r = bus.in_ready;
      pat[4-c] = r;
      tick();
      if (r && idx < 3) idx++;
    end
    bus.in_valid = 1'b0;
    total++; if (pat !== 5'b11010) begin bad++; $display("FAIL three_in_ready got=%b want=11010", pat); end
    collect(d, lat, 0);
    total++; if (d !== 32'h40C0_0000) begin bad++; $display("FAIL three_sum got=%h want=40c00000", d); end
  endtask

  task automatic test_zero_len;
    logic [31:0] d;
    int lat;
    start_op(0);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL zero_valid got=%b want=1", bus.out_valid); end
    total++; if (bus.out_data !== 32'h0) begin bad++; $display("FAIL zero_data got=%h want=00000000", bus.out_data); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL zero_in_ready got=%b want=0", bus.in_ready); end
    collect(d, lat, 0);
  endtask

  task automatic test_backpressure;
    start_op(1);
    send(q2f(10), 0);
    for (int c = 0; c < 5; c++) begin
      bus.start = c[0];
      bus.len = 8'd3;
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid c=%0d got=%b want=1", c, bus.out_valid); end
      total++; if (bus.out_data !== q2f(10)) begin bad++; $display("FAIL bp_data c=%0d got=%h want=%h", c, bus.out_data, q2f(10)); end
      tick();
    end
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL bp_busy got=%b want=0", bus.busy); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drop got=%b want=0", bus.out_valid); end
    tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL bp_start_ignored got=%b want=0", bus.busy); end
  endtask

  task automatic test_stall;
    logic [31:0] d;
    int lat;
    start_op(2);
    send(32'h3FC0_0000, 0);
    send(32'h3FC0_0000, 2);
    collect(d, lat, 0);
    total++; if (d !== 32'h4040_0000) begin bad++; $display("FAIL stall_sum got=%h want=40400000", d); end
  endtask

  task automatic test_random;
    logic [31:0] d;
    int n, k, sum, lat;
    for (int it = 0; it < 25; it++) begin
      n = int'($urandom_range(0, 8));
      sum = 0;
      start_op(n);
      for (int e = 0; e < n; e++) begin
        k = int'($urandom_range(1, 64));
        if ($urandom_range(0, 1) == 1) k = -k;
        sum += k;
        send(q2f(k), int'($urandom_range(0, 2)));
      end
      collect(d, lat, int'($urandom_range(0, 3)));
      total++; if (d !== q2f(sum)) begin bad++; $display("FAIL rand_sum it=%0d n=%0d got=%h want=%h", it, n, d, q2f(sum)); end
      total++; if (lat !== (n > 1 ? 1 : 0)) begin bad++; $display("FAIL rand_latency it=%0d got=%0d want=%0d", it, lat, n > 1 ? 1 : 0); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.len = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_sign_mix();
    test_three_term();
    test_zero_len();
    test_backpressure();
    test_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
